// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one 4x4 signed Booth/Brent-Kung multiplier between NREQ requesters.
// Two-stage datapath with tagged result FIFO; MULT_ARB_PERF_EN adds per-requester grant counters.

module mult4s_booth4_brentkung (
  input  logic signed [3:0] a,
  input  logic signed [3:0] b,
  output logic signed [7:0] p
);

  logic [7:0] a_ext;
  logic [7:0] pp0;
  logic [7:0] pp1_raw;
  logic [7:0] pp1;
  logic [7:0] g;
  logic [7:0] pr;
  logic [7:0] c;
  logic g10, p10, g32, p32, g54, p54;
  logic g30, p30, g50, g20, g40, g60;

  function automatic logic [7:0] booth_pp(input logic [2:0] grp, input logic [7:0] x);
    logic [7:0] val;
    val = 8'h00;
    case (grp)
      3'b001, 3'b010: val = x;
      3'b011:         val = x << 1;
      3'b100:         val = ~(x << 1) + 8'd1;
      3'b101, 3'b110: val = ~x + 8'd1;
      default:        val = 8'h00;
    endcase
    return val;
  endfunction

  assign a_ext   = {{4{a[3]}}, a};
  assign pp0     = booth_pp({b[1:0], 1'b0}, a_ext);
  assign pp1_raw = booth_pp(b[3:1], a_ext);
  assign pp1     = {pp1_raw[5:0], 2'b00};

  assign g  = pp0 & pp1;
  assign pr = pp0 ^ pp1;

  // Brent-Kung prefix tree: up-sweep on pairs, then fill-in of the odd spans.
  assign g10 = g[1] | (pr[1] & g[0]);
  assign p10 = pr[1] & pr[0];
  assign g32 = g[3] | (pr[3] & g[2]);
  assign p32 = pr[3] & pr[2];
  assign g54 = g[5] | (pr[5] & g[4]);
  assign p54 = pr[5] & pr[4];
  assign g30 = g32 | (p32 & g10);
  assign p30 = p32 & p10;
  assign g50 = g54 | (p54 & g30);
  assign g20 = g[2] | (pr[2] & g10);
  assign g40 = g[4] | (pr[4] & g30);
  assign g60 = g[6] | (pr[6] & g50);

  assign c = {g60, g50, g40, g30, g20, g10, g[0], 1'b0};
  assign p = pr ^ c;

endmodule

module mult_share_arbiter #(
  parameter  int NREQ       = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_multiplicand,
  input  logic [4*NREQ-1:0] req_multiplier,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_product
`ifdef MULT_ARB_PERF_EN
  ,
  output logic [16*NREQ-1:0] grant_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [IDW-1:0] rr_ptr;
  logic [IDW:0]   scan_idx;
  logic [NREQ-1:0] grant_vec;
  logic [IDW-1:0] grant_id;
  logic           grant_any;
  logic [CW:0]    occupancy;
  logic           issue_ok;
  logic [3:0]     sel_a;
  logic [3:0]     sel_b;

  logic                s1_valid;
  logic [IDW-1:0]      s1_id;
  logic signed [3:0]   s1_a;
  logic signed [3:0]   s1_b;
  logic signed [7:0]   mult_p;

  logic                s2_valid;
  logic [IDW-1:0]      s2_id;
  logic [7:0]          s2_p;

  logic [7:0]     fifo_prod [FIFO_DEPTH];
  logic [IDW-1:0] fifo_id   [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  fifo_count;
  logic           push;
  logic           pop;

  // Same-cycle pops are deliberately not credited, so a full pipe never over-issues.
  assign occupancy = (CW+1)'(s1_valid) + (CW+1)'(s2_valid) + (CW+1)'(fifo_count);
  assign issue_ok  = rst_n && (occupancy < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    grant_vec = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    if (issue_ok) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
        if (scan_idx >= (IDW+1)'(NREQ)) scan_idx = scan_idx - (IDW+1)'(NREQ);
        if (!grant_any && req_valid[scan_idx[IDW-1:0]]) begin
          grant_any                     = 1'b1;
          grant_id                      = scan_idx[IDW-1:0];
          grant_vec[scan_idx[IDW-1:0]]  = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant_vec;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id == IDW'(k)) begin
        sel_a = req_multiplicand[4*k +: 4];
        sel_b = req_multiplier[4*k +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= grant_any;
      if (grant_any) begin
        s1_id  <= grant_id;
        s1_a   <= sel_a;
        s1_b   <= sel_b;
        rr_ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
      end
    end
  end

  mult4s_booth4_brentkung u_mult (
    .a (s1_a),
    .b (s1_b),
    .p (mult_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_p     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_p     <= mult_p;
    end
  end

  assign push = s2_valid;
  assign pop  = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_prod[k] <= '0;
        fifo_id[k]   <= '0;
      end
    end else begin
      if (push) begin
        fifo_prod[wr_ptr] <= s2_p;
        fifo_id[wr_ptr]   <= s2_id;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (!push && pop) fifo_count <= fifo_count - CW'(1);
    end
  end

  assign rsp_valid   = (fifo_count != '0);
  assign rsp_id      = fifo_id[rd_ptr];
  assign rsp_product = fifo_prod[rd_ptr];

`ifdef MULT_ARB_PERF_EN
  logic [15:0] gcnt [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREQ; k++) gcnt[k] <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (grant_vec[k] && gcnt[k] != 16'hFFFF) gcnt[k] <= gcnt[k] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_count = '0;
    for (int k = 0; k < NREQ; k++) grant_count[16*k +: 16] = gcnt[k];
  end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: fairness, latency, backpressure, corners, reset.
// Counter checks are compiled in when MULT_ARB_PERF_EN is defined.

module tb_mult_share_arbiter;

  localparam int NREQ       = 4;
  localparam int FIFO_DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_multiplicand;
  logic [15:0] req_multiplier;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_product;
`ifdef MULT_ARB_PERF_EN
  logic [63:0] grant_count;
`endif

  int total = 0;
  int bad   = 0;

  mult_share_arbiter #(.NREQ(NREQ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_multiplicand (req_multiplicand),
    .req_multiplier   (req_multiplier),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_id           (rsp_id),
    .rsp_product      (rsp_product)
`ifdef MULT_ARB_PERF_EN
    ,
    .grant_count      (grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [15:0] mc,
                               input logic [15:0] mp, input logic rr);
    req_valid        = v;
    req_multiplicand = mc;
    req_multiplier   = mp;
    rsp_ready        = rr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkRsp(input string tag, input logic [1:0] id, input logic [7:0] prod);
    checkOutput({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    checkOutput({tag, "_id"}, 64'(rsp_id), 64'(id));
    checkOutput({tag, "_prod"}, 64'(rsp_product), 64'(prod));
  endtask

  initial begin
    logic [3:0] exp_rdy;
    logic [1:0] exp_id;
    logic [7:0] exp_prod;
    logic [3:0] bp_rdy [5];
    logic [7:0] fair_prod [4];
    logic [7:0] corner_prod [4];

    bp_rdy      = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0000};
    fair_prod   = '{8'h02, 8'h04, 8'h06, 8'h08};
    corner_prod = '{8'h40, 8'hC8, 8'h31, 8'h00};

    // Reset: outputs idle even with every requester asking.
    rst_n = 1'b0;
    applyStimulus(4'hF, 16'h4321, 16'h2222, 1'b0);
    tick();
    tick();
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rsp_id", 64'(rsp_id), 64'd0);
    checkOutput("reset_rsp_product", 64'(rsp_product), 64'd0);
    checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
    applyStimulus(4'h0, 16'h0, 16'h0, 1'b0);
    rst_n = 1'b1;
    #1;

    // Fairness: requester i computes (i+1)*2, grants rotate 0..3 twice.
    for (int k = 0; k <= 10; k++) begin
      applyStimulus((k < 8) ? 4'hF : 4'h0, 16'h4321, 16'h2222, 1'b1);
      if (k < 8) begin
        exp_rdy = 4'b0001 << (k % 4);
        checkOutput($sformatf("fair_grant%0d", k), 64'(req_ready), 64'(exp_rdy));
      end
      if (k >= 3) begin
        exp_id   = 2'((k - 3) % 4);
        exp_prod = fair_prod[(k - 3) % 4];
        checkRsp($sformatf("fair_rsp%0d", k - 3), exp_id, exp_prod);
      end else begin
        checkOutput($sformatf("fair_empty%0d", k), 64'(rsp_valid), 64'd0);
      end
      tick();
    end
    checkOutput("fair_drained", 64'(rsp_valid), 64'd0);

    // Single request: requester 2, 3 * -2.
    applyStimulus(4'b0100, 16'h0300, 16'h0E00, 1'b0);
    checkOutput("single_ready", 64'(req_ready), 64'b0100);
    tick();
    applyStimulus(4'h0, 16'h0, 16'h0, 1'b0);
    checkOutput("single_lat1", 64'(rsp_valid), 64'd0);
    tick();
    checkOutput("single_lat2", 64'(rsp_valid), 64'd0);
    tick();
    checkRsp("single_rsp", 2'd2, 8'hFA);
    applyStimulus(4'h0, 16'h0, 16'h0, 1'b1);
    tick();
    checkOutput("single_popped", 64'(rsp_valid), 64'd0);

    // Backpressure: pointer now at 3, FIFO holds exactly four results.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'hF, 16'h4321, 16'h2222, 1'b0);
      checkOutput($sformatf("bp_grant%0d", k), 64'(req_ready), 64'(bp_rdy[k]));
      tick();
    end
    tick();
    tick();
    applyStimulus(4'hF, 16'h4321, 16'h2222, 1'b0);
    checkOutput("bp_full_hold", 64'(req_ready), 64'd0);
    checkRsp("bp_head", 2'd3, 8'h08);
    applyStimulus(4'hF, 16'h4321, 16'h2222, 1'b1);
    checkOutput("bp_pop_not_credited", 64'(req_ready), 64'd0);
    tick();
    applyStimulus(4'hF, 16'h4321, 16'h2222, 1'b0);
    checkOutput("bp_one_more", 64'(req_ready), 64'b1000);
    tick();
    applyStimulus(4'h0, 16'h0, 16'h0, 1'b1);
    checkOutput("bp_no_extra", 64'(req_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      checkRsp($sformatf("bp_drain%0d", k), 2'(k), fair_prod[k]);
      tick();
    end
    checkOutput("bp_drained", 64'(rsp_valid), 64'd0);

    // Arithmetic corners, one per requester.
    for (int k = 0; k < 8; k++) begin
      applyStimulus((k < 4) ? 4'hF : 4'h0, 16'h0788, 16'hB778, 1'b1);
      if (k < 4) begin
        exp_rdy = 4'b0001 << k;
        checkOutput($sformatf("corner_grant%0d", k), 64'(req_ready), 64'(exp_rdy));
      end
      if (k >= 3 && k <= 6) checkRsp($sformatf("corner%0d", k - 3), 2'(k - 3), corner_prod[k - 3]);
      tick();
    end
    checkOutput("corner_drained", 64'(rsp_valid), 64'd0);

    // Reset with three results in flight.
    applyStimulus(4'hF, 16'h0788, 16'hB778, 1'b0);
    tick();
    tick();
    tick();
    checkRsp("inflight_head", 2'd0, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("midrst_req_ready", 64'(req_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(4'h0, 16'h0788, 16'hB778, 1'b1);
    checkOutput("postrst_empty", 64'(rsp_valid), 64'd0);
    applyStimulus(4'hF, 16'h0788, 16'hB778, 1'b1);
    checkOutput("postrst_ptr0", 64'(req_ready), 64'b0001);
    tick();
    applyStimulus(4'h0, 16'h0788, 16'hB778, 1'b1);
    tick();
    tick();
    checkRsp("postrst_rsp", 2'd0, 8'h40);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("postrst_no_stale%0d", k), 64'(rsp_valid), 64'd0);
    end

`ifdef MULT_ARB_PERF_EN
    #1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("perf_reset", grant_count, 64'd0);
    applyStimulus(4'b0010, 16'h0, 16'h0, 1'b1);
    for (int k = 0; k < 10; k++) tick();
    applyStimulus(4'b1000, 16'h0, 16'h0, 1'b1);
    for (int k = 0; k < 3; k++) tick();
    applyStimulus(4'h0, 16'h0, 16'h0, 1'b1);
    tick();
    checkOutput("perf_counts", grant_count, {16'd3, 16'd0, 16'd10, 16'd0});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one 4x4 signed Booth/Brent-Kung multiplier core (mult4s_booth4_brentkung, combinational) between NREQ requesters.
- Round-robin arbitration on valid/ready request ports feeds a 2-stage registered datapath: operand register, then product register.
- Results are tagged with the requester ID and buffered in a result FIFO with valid/ready backpressure.
- Issue is credit-gated so the FIFO never overflows. Sits between compute clients and the shared multiplier in the multiplier evaluation harnesses.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FIFO_DEPTH, 4, result FIFO entries (power of two, >= 4).
- IDW, $clog2(NREQ), requester ID width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant. One-hot or zero.
- req_multiplicand  input  4*NREQ  signed operand; requester i uses bits [4i+3:4i].
- req_multiplier  input  4*NREQ  signed operand, same packing.
- rsp_valid  output  1  FIFO head valid.
- rsp_ready  input  1  consumer accepts head.
- rsp_id  output  IDW  requester index of head result.
- rsp_product  output  8  signed two's-complement product of head.
- grant_count  output  16*NREQ  per-requester accepted-request counters; present only with MULT_ARB_PERF_EN.

Behaviour:
- Reset (async assert, sync-safe deassert is the integrator's job) clears:
  - RR pointer to 0.
  - s1_valid, s2_valid.
  - FIFO pointers and count.
  - All operand, product and ID registers to 0.
  - Resulting outputs: rsp_valid=0, rsp_id=0, rsp_product=0, req_ready=0.
- Reset asserted mid-operation discards all in-flight and buffered results. Nothing is replayed.
- Credit: occupancy = s1_valid + s2_valid + fifo_count. Issue is allowed only when occupancy < FIFO_DEPTH. Same-cycle pop is not credited (conservative).
- Arbitration (combinational):
  - If issue is allowed, search req_valid starting at the RR pointer, wrapping modulo NREQ. The first set bit i wins.
  - req_ready[i]=1 for the winner only.
  - req_ready may depend on req_valid. Requesters must hold valid and operands stable until ready.
- Handshake at an edge where req_valid[i]&req_ready[i]:
  - Operands and ID i are captured into stage 1; s1_valid=1.
  - The RR pointer becomes (i+1) mod NREQ.
  - With no handshake, the pointer holds and s1_valid=0.
- Stage 2 captures the multiplier output, s1 ID and s1_valid every cycle. There is no stall: credit guarantees FIFO space.
- The FIFO pushes when s2_valid=1 and pops when rsp_valid&rsp_ready. Simultaneous push and pop, including when full, is legal and leaves the count unchanged.
- rsp_* present the FIFO head. rsp_valid = (fifo_count != 0).
- Latency: a request accepted at edge E0 gives rsp_valid high after edge E2 (3 cycles handshake-to-response) when the FIFO was empty.
- Throughput: 1 result/cycle sustained with rsp_ready=1.
- Results leave in grant order. rsp_id identifies the requester.
- Arithmetic: full-precision 8-bit signed result, no saturation or truncation. Range -56..64. -8*-8 = 64 = 8'h40.
- Wrap-around: RR pointer wraps from NREQ-1 to 0; FIFO pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- MULT_ARB_PERF_EN defined:
  - grant_count port exists.
  - Counter i increments on each handshake of requester i.
  - Counters saturate at 16'hFFFF and reset to 0 on rst_n.
- Undefined: no counters and no grant_count port. Datapath and timing are identical.

Test Plan:
- Single request: requester 2 sends 3 * -2 -> req_ready[2] same cycle; 3 cycles later rsp_valid=1, rsp_id=2, rsp_product=8'hFA.
- Fairness: all 4 req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0,... on consecutive cycles; responses return in the same ID order with 1/cycle throughput.
- Backpressure: rsp_ready=0, all requesters valid -> exactly FIFO_DEPTH=4 accepts, then req_ready=0; raising rsp_ready for one cycle pops one entry and allows exactly one further grant; no loss or duplication.
- Corners: -8*-8 -> 8'h40; -8*7 -> 8'hC8; 7*7 -> 8'h31; 0*-5 -> 8'h00.
- Reset mid-operation: three requests in flight, drop rst_n asynchronously between edges -> rsp_valid=0 and req_ready=0 immediately; after release, RR pointer is 0 and no stale responses appear.
- MULT_ARB_PERF_EN: 10 grants to requester 1 and 3 to requester 3 -> grant_count fields read 10 and 3, others 0; forcing a counter to 16'hFFFF and granting again keeps 16'hFFFF.
